mtr_drive: RTL and testbench
============================

# mtr_drive

Dual-channel H-bridge PWM driver downstream of the balance controller. It consumes the registered signed wheel speeds `lft_spd`/`rght_spd` and converts each to an 11-bit PWM duty with a direction. Per-period slew limiting and a one-period blanking interval on every direction reversal protect the bridges. Outputs drive the forward/reverse gate inputs of the left and right motor bridges directly.

## Interface
- `SLEW`, default 64: max duty change per PWM period, in counts; legal range 1..2047.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: drive enable, tied to `pwr_up`; low forces the bridges off.
- `lft_spd` in 12: signed left speed command.
- `rght_spd` in 12: signed right speed command.
- `lft_fwd`, `lft_rev` out 1 each: left bridge forward/reverse PWM.
- `rght_fwd`, `rght_rev` out 1 each: right bridge forward/reverse PWM.
- `lft_duty`, `rght_duty` out 11 each: applied duty magnitude per channel.
- `prd_strt` out 1: one-cycle pulse marking the first output cycle of each PWM period.

## Operation
- Shared free-running 11-bit counter `cnt` runs 0..2047 and wraps to 0. Period is 2048 clks.
- Target per channel, sampled only in the `cnt==2047` cycle:
  - `tgt_dir` = sign bit of the speed (0 = forward; speed 0 is forward).
  - `tgt_mag` = |speed|, saturated to 2047 (-2048 gives 2047).
- Per-channel state: `dir` (1b), `mag` (11b, drives `*_duty`), FSM {RUN, BLANK}.
- Update in the `cnt==2047` cycle:
  - RUN, `tgt_dir==dir`: `mag` moves toward `tgt_mag` by min(|tgt_mag-mag|, SLEW). No overshoot.
  - RUN, `tgt_dir!=dir`, `mag>SLEW`: `mag -= SLEW`. Stay in RUN.
  - RUN, `tgt_dir!=dir`, `mag<=SLEW`: `mag=0`, go to BLANK. This also applies when `mag` is already 0.
  - BLANK: `dir=tgt_dir`, `mag=min(tgt_mag,SLEW)`, go to RUN. BLANK therefore lasts exactly one period.
- Outputs, registered:
  - In RUN: `fwd = !dir && (cnt<mag)` and `rev = dir && (cnt<mag)`.
  - In BLANK: both outputs 0.
  - `fwd` and `rev` are never high together. Max duty is 2047/2048, and `mag=0` gives constant low.
- Channels are fully independent and share only `cnt`.
- `en` low, checked every cycle:
  - Next edge: `mag=0`, `dir=0`, state RUN, all four PWM outputs 0.
  - `cnt` and `prd_strt` keep running.
  - After `en` rises, ramping starts from 0 at the next `cnt==2047`.

## Timing
- Reset (async, `rst` high) sets:
  - `cnt=0`, `mag=0`, `dir=0`, state RUN.
  - `*_fwd`, `*_rev`, `prd_strt` = 0 and `*_duty` = 0.
- First edge after `rst` deasserts: `cnt` goes 0→1.
- `prd_strt` is registered and goes high in the cycle after `cnt==0`. Period is 2048 cycles.
- Speed inputs are sampled only in the `cnt==2047` cycle. Changes at any other time are ignored until that cycle.
- New `mag` takes effect with `cnt==0` (next edge). The output reflecting it appears one cycle later, aligned with `prd_strt`.
- Output high width in a period equals `mag` cycles exactly.
- Reversal from magnitude M to opposite direction: ceil(M/SLEW) periods of ramp-down (≥1), then 1 BLANK period, then the ramp-up starts at min(tgt,SLEW).
- `en` deassert mid-period truncates the current pulse on the next edge.
- Reset mid-period truncates the pulse immediately (async).

## Test plan
- Ramp up:
  - Stimulus: reset, `en=1`, `lft_spd=+500`.
  - Required: `lft_duty` = 64,128,...,448,500 over successive periods, with `lft_fwd` high exactly `lft_duty` cycles per period.
  - Required: `lft_rev` stays 0, and the right channel stays 0.
- Reversal:
  - Stimulus: steady `lft_duty=500` fwd, then `lft_spd=-300`.
  - Required: duty 436,372,308,244,180,116,52, then 0 with BLANK (both low for 2048 cycles).
  - Required: then `lft_rev` with duty 64,128,...,256,300. `fwd` and `rev` never overlap.
- Saturation:
  - Stimulus: `rght_spd=-2048` with `SLEW=2047`.
  - Required: BLANK period, then `rght_duty=2047` and `rght_rev` high 2047 of 2048 cycles.
- Sampling window:
  - Stimulus: toggle `lft_spd` between +100 and +900 except in the `cnt==2047` cycle.
  - Required: `lft_duty` tracks only the values present in the `cnt==2047` cycle.
- Enable drop:
  - Stimulus: `en` falls mid-pulse at duty 800.
  - Required: outputs low the next cycle and `lft_duty=0`.
  - Required: after `en` rises, duty restarts at 64.
- Reset mid-operation:
  - Stimulus: assert `rst` asynchronously while `rght_rev` is high.
  - Required: all outputs 0 immediately and `cnt=0`.
  - Required: after release, `prd_strt` first pulses 2048 cycles later.

Source files
------------

// File: rtl/mtr_drive.sv
// Dual-channel H-bridge PWM driver: turns signed wheel speeds into slew-limited
// PWM duty with a one-period blanking interval on every direction reversal.
module mtr_drive #(
   parameter int SLEW = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [11:0] lft_spd,
   input  logic signed [11:0] rght_spd,
   output logic               lft_fwd,
   output logic               lft_rev,
   output logic               rght_fwd,
   output logic               rght_rev,
   output logic        [10:0] lft_duty,
   output logic        [10:0] rght_duty,
   output logic               prd_strt
);

   localparam logic [0:0]  RUN     = 1'b0;
   localparam logic [0:0]  BLANK   = 1'b1;
   localparam logic [10:0] SlewMag = 11'(SLEW);
   localparam logic [10:0] CntMax  = 11'd2047;

   logic [10:0] cnt_q;
   logic        pre_q;
   logic        prd_q;
   logic [1:0]  dir_q, dir_d;
   logic [0:0]  st_q  [2];
   logic [0:0]  st_d  [2];
   logic [10:0] mag_q [2];
   logic [10:0] mag_d [2];
   logic [1:0]  fwd_q, rev_q;

   // Per-channel target extraction and once-per-period slew/reversal update.
   // Index 0 is the left channel, index 1 the right channel.
   always_comb begin : nextState
      logic [11:0] spd;
      logic        tgtDir;
      logic [10:0] tgtMag;
      logic [10:0] gap;
      spd    = '0;
      tgtDir = 1'b0;
      tgtMag = '0;
      gap    = '0;
      dir_d  = dir_q;
      mag_d  = mag_q;
      st_d   = st_q;
      for (int c = 0; c < 2; c++) begin
         spd    = (c == 0) ? lft_spd : rght_spd;
         tgtDir = spd[11];
         if (!spd[11])
            tgtMag = spd[10:0];
         else if (spd == 12'h800)
            tgtMag = CntMax;
         else
            tgtMag = ~spd[10:0] + 11'd1;
         gap = (tgtMag > mag_q[c]) ? (tgtMag - mag_q[c]) : (mag_q[c] - tgtMag);
         if (gap > SlewMag)
            gap = SlewMag;

         if (!en) begin
            dir_d[c] = 1'b0;
            mag_d[c] = '0;
            st_d[c]  = RUN;
         end else if (cnt_q == CntMax) begin
            if (st_q[c] == BLANK) begin
               dir_d[c] = tgtDir;
               mag_d[c] = (tgtMag > SlewMag) ? SlewMag : tgtMag;
               st_d[c]  = RUN;
            end else if (tgtDir == dir_q[c]) begin
               mag_d[c] = (tgtMag > mag_q[c]) ? (mag_q[c] + gap) : (mag_q[c] - gap);
            end else if (mag_q[c] > SlewMag) begin
               mag_d[c] = mag_q[c] - SlewMag;
            end else begin
               mag_d[c] = '0;
               st_d[c]  = BLANK;
            end
         end
      end
   end

   // The period marker is delayed through pre_q so no pulse follows the
   // counter value held during reset; the first one comes after a real wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         pre_q <= 1'b0;
         prd_q <= 1'b0;
         dir_q <= '0;
         fwd_q <= '0;
         rev_q <= '0;
         for (int c = 0; c < 2; c++) begin
            st_q[c]  <= RUN;
            mag_q[c] <= '0;
         end
      end else begin
         cnt_q <= cnt_q + 11'd1;
         pre_q <= (cnt_q == CntMax);
         prd_q <= pre_q;
         dir_q <= dir_d;
         for (int c = 0; c < 2; c++) begin
            st_q[c]  <= st_d[c];
            mag_q[c] <= mag_d[c];
            fwd_q[c] <= en && (st_q[c] == RUN) && !dir_q[c] && (cnt_q < mag_q[c]);
            rev_q[c] <= en && (st_q[c] == RUN) &&  dir_q[c] && (cnt_q < mag_q[c]);
         end
      end
   end

   assign lft_fwd   = fwd_q[0];
   assign lft_rev   = rev_q[0];
   assign rght_fwd  = fwd_q[1];
   assign rght_rev  = rev_q[1];
   assign lft_duty  = mag_q[0];
   assign rght_duty = mag_q[1];
   assign prd_strt  = prd_q;

endmodule

// File: tb/tb_mtr_drive.sv
// Testbench for mtr_drive: a default-slew instance and a SLEW=2047 instance
// share clock, reset and enable and are checked against a per-period model.
module tb_mtr_drive;

   logic               clk = 1'b0;
   logic               rst;
   logic               en;
   logic signed [11:0] lftSpd, rghtSpd, sLftSpd, sRghtSpd;
   logic               lftFwd, lftRev, rghtFwd, rghtRev, prdStrt;
   logic               sLftFwd, sLftRev, sRghtFwd, sRghtRev, sPrdStrt;
   logic        [10:0] lftDuty, rghtDuty, sLftDuty, sRghtDuty;

   int nChecks = 0;
   int nPass   = 0;
   int periodIdx = 0;
   bit firstPeriod;

   // model state: 0/1 = default instance L/R, 2/3 = SLEW 2047 instance L/R
   int mMag   [4];
   int mDir   [4];
   int mBlank [4];

   bit obsFwd  [4];
   bit obsRev  [4];
   int obsDuty [4];

   mtr_drive dut (
      .clk(clk), .rst(rst), .en(en), .lft_spd(lftSpd), .rght_spd(rghtSpd),
      .lft_fwd(lftFwd), .lft_rev(lftRev), .rght_fwd(rghtFwd), .rght_rev(rghtRev),
      .lft_duty(lftDuty), .rght_duty(rghtDuty), .prd_strt(prdStrt)
   );

   mtr_drive #(.SLEW(2047)) dutSat (
      .clk(clk), .rst(rst), .en(en), .lft_spd(sLftSpd), .rght_spd(sRghtSpd),
      .lft_fwd(sLftFwd), .lft_rev(sLftRev), .rght_fwd(sRghtFwd), .rght_rev(sRghtRev),
      .lft_duty(sLftDuty), .rght_duty(sRghtDuty), .prd_strt(sPrdStrt)
   );

   always #5 clk = ~clk;

   function automatic void modelZero();
      for (int ch = 0; ch < 4; ch++) begin
         mMag[ch] = 0; mDir[ch] = 0; mBlank[ch] = 0;
      end
   endfunction

   // One period-boundary decision of a channel, straight from the speed rules.
   function automatic void modelStep(int ch, int spd);
      int slew, tDir, tMag;
      slew = (ch < 2) ? 64 : 2047;
      tDir = (spd < 0) ? 1 : 0;
      tMag = (spd < 0) ? ((-spd > 2047) ? 2047 : -spd) : spd;
      if (mBlank[ch] != 0) begin
         mDir[ch]   = tDir;
         mMag[ch]   = (tMag < slew) ? tMag : slew;
         mBlank[ch] = 0;
      end else if (tDir == mDir[ch]) begin
         if (tMag > mMag[ch])
            mMag[ch] += ((tMag - mMag[ch]) < slew) ? (tMag - mMag[ch]) : slew;
         else
            mMag[ch] -= ((mMag[ch] - tMag) < slew) ? (mMag[ch] - tMag) : slew;
      end else if (mMag[ch] > slew) begin
         mMag[ch] -= slew;
      end else begin
         mMag[ch]   = 0;
         mBlank[ch] = 1;
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      obsFwd[0] = lftFwd;  obsFwd[1] = rghtFwd;  obsFwd[2] = sLftFwd;  obsFwd[3] = sRghtFwd;
      obsRev[0] = lftRev;  obsRev[1] = rghtRev;  obsRev[2] = sLftRev;  obsRev[3] = sRghtRev;
      obsDuty[0] = int'(lftDuty);  obsDuty[1] = int'(rghtDuty);
      obsDuty[2] = int'(sLftDuty); obsDuty[3] = int'(sRghtDuty);
   endtask

   task automatic doReset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      modelZero();
      firstPeriod = 1'b1;
   endtask

   // Runs one full period starting at counter value 0 and checks duty, pulse
   // widths, exclusivity and the period marker against the model.
   task automatic runPeriod(input bit noise, input int dropAt, input int riseAt, input bit chkCnt);
      int fwdCnt [4];
      int revCnt [4];
      int dutyAt0 [4];
      int spdNow [4];
      int overlap, prdCnt, prdAt0, lftReal, expF, expR, expPrd;
      bit expBit;
      overlap = 0; prdCnt = 0; prdAt0 = 0;
      lftReal = ($urandom_range(0, 1) == 1) ? 900 : 100;
      for (int ch = 0; ch < 4; ch++) begin
         fwdCnt[ch] = 0; revCnt[ch] = 0; dutyAt0[ch] = 0;
      end
      for (int j = 0; j < 2048; j++) begin
         if (j == dropAt) en = 1'b0;
         if (j == riseAt) en = 1'b1;
         if (noise)
            lftSpd = (j == 2047) ? 12'(lftReal) :
                     (($urandom_range(0, 1) == 1) ? 12'sd900 : 12'sd100);
         tick();
         for (int ch = 0; ch < 4; ch++) begin
            if (obsFwd[ch]) fwdCnt[ch]++;
            if (obsRev[ch]) revCnt[ch]++;
            if (obsFwd[ch] && obsRev[ch]) overlap++;
            if (j == 0) dutyAt0[ch] = obsDuty[ch];
         end
         if (prdStrt)  begin prdCnt++; if (j == 0) prdAt0++; end
         if (sPrdStrt) begin prdCnt++; if (j == 0) prdAt0++; end
         if (dropAt > 0 && j == dropAt - 1) begin
            expBit = (mBlank[2] == 0) && (mDir[2] == 0) && (mMag[2] > j);
            nChecks++;
            if (sLftFwd !== expBit)
               $display("[TB] FAIL pre_drop_pulse: sat lft_fwd=%0b want %0b", sLftFwd, expBit);
            else nPass++;
         end
         if (j == dropAt) begin
            nChecks++;
            if ({lftFwd, lftRev, rghtFwd, rghtRev, sLftFwd, sLftRev, sRghtFwd, sRghtRev} !== 8'h00)
               $display("[TB] FAIL drop_outputs: pwm=%b want 00000000",
                        {lftFwd, lftRev, rghtFwd, rghtRev, sLftFwd, sLftRev, sRghtFwd, sRghtRev});
            else nPass++;
            nChecks++;
            if (lftDuty !== 11'd0 || sLftDuty !== 11'd0)
               $display("[TB] FAIL drop_duty: lft_duty=%0d sat lft_duty=%0d want 0", lftDuty, sLftDuty);
            else nPass++;
         end
      end

      for (int ch = 0; ch < 4; ch++) begin
         nChecks++;
         if (dutyAt0[ch] !== mMag[ch])
            $display("[TB] FAIL duty ch%0d period %0d: got %0d want %0d", ch, periodIdx, dutyAt0[ch], mMag[ch]);
         else nPass++;
         if (chkCnt) begin
            expF = (mBlank[ch] == 0 && mDir[ch] == 0) ? mMag[ch] : 0;
            expR = (mBlank[ch] == 0 && mDir[ch] == 1) ? mMag[ch] : 0;
            nChecks++;
            if (fwdCnt[ch] !== expF || revCnt[ch] !== expR)
               $display("[TB] FAIL width ch%0d period %0d: fwd=%0d rev=%0d want fwd=%0d rev=%0d",
                        ch, periodIdx, fwdCnt[ch], revCnt[ch], expF, expR);
            else nPass++;
         end
      end
      nChecks++;
      if (overlap !== 0)
         $display("[TB] FAIL overlap period %0d: got %0d cycles want 0", periodIdx, overlap);
      else nPass++;
      expPrd = firstPeriod ? 0 : 2;
      nChecks++;
      if (prdCnt !== expPrd || prdAt0 !== expPrd)
         $display("[TB] FAIL prd_strt period %0d: pulses=%0d at_start=%0d want %0d",
                  periodIdx, prdCnt, prdAt0, expPrd);
      else nPass++;

      spdNow[0] = lftSpd; spdNow[1] = rghtSpd; spdNow[2] = sLftSpd; spdNow[3] = sRghtSpd;
      if (dropAt >= 0) modelZero();
      if (en)
         for (int ch = 0; ch < 4; ch++) modelStep(ch, spdNow[ch]);
      firstPeriod = 1'b0;
      periodIdx++;
   endtask

   task automatic test_reset();
      en = 1'b0;
      lftSpd = '0; rghtSpd = '0; sLftSpd = '0; sRghtSpd = '0;
      rst = 1'b1;
      #3;
      nChecks++;
      if ({lftFwd, lftRev, rghtFwd, rghtRev, prdStrt} !== 5'b0)
         $display("[TB] FAIL reset_pwm: got %b want 00000", {lftFwd, lftRev, rghtFwd, rghtRev, prdStrt});
      else nPass++;
      nChecks++;
      if (lftDuty !== 11'd0 || rghtDuty !== 11'd0)
         $display("[TB] FAIL reset_duty: lft=%0d rght=%0d want 0", lftDuty, rghtDuty);
      else nPass++;
      doReset();
   endtask

   task automatic test_ramp_up();
      en = 1'b1;
      lftSpd = 12'sd500;
      for (int p = 0; p < 10; p++) runPeriod(1'b0, -1, -1, 1'b1);
   endtask

   task automatic test_reversal();
      lftSpd = -12'sd300;
      for (int p = 0; p < 13; p++) runPeriod(1'b0, -1, -1, 1'b1);
   endtask

   task automatic test_sampling_window();
      for (int p = 0; p < 3; p++) runPeriod(1'b1, -1, -1, 1'b1);
   endtask

   task automatic test_random();
      for (int p = 0; p < 3; p++) begin
         lftSpd   = 12'($urandom_range(0, 4095));
         rghtSpd  = 12'($urandom_range(0, 4095));
         sLftSpd  = 12'($urandom_range(0, 4095));
         sRghtSpd = 12'($urandom_range(0, 4095));
         runPeriod(1'b0, -1, -1, 1'b1);
      end
   endtask

   task automatic test_saturation();
      doReset();
      lftSpd = 12'sd500; rghtSpd = -12'sd1000;
      sLftSpd = 12'sd800; sRghtSpd = -12'sd2048;
      for (int p = 0; p < 3; p++) runPeriod(1'b0, -1, -1, 1'b1);
      nChecks++;
      if (mMag[3] !== 2047 || mDir[3] !== 1)
         $display("[TB] FAIL sat_model: model mag=%0d dir=%0d want 2047/1", mMag[3], mDir[3]);
      else nPass++;
   endtask

   task automatic test_reset_mid();
      bit expRev;
      for (int j = 0; j <= 100; j++) tick();
      expRev = (mBlank[3] == 0) && (mDir[3] == 1) && (mMag[3] > 100);
      nChecks++;
      if (sRghtRev !== expRev)
         $display("[TB] FAIL pre_reset_rev: got %0b want %0b", sRghtRev, expRev);
      else nPass++;
      #1 rst = 1'b1;
      #1;
      nChecks++;
      if ({lftFwd, lftRev, rghtFwd, rghtRev, sLftFwd, sLftRev, sRghtFwd, sRghtRev, prdStrt} !== 9'b0)
         $display("[TB] FAIL async_reset_pwm: got %b want 000000000",
                  {lftFwd, lftRev, rghtFwd, rghtRev, sLftFwd, sLftRev, sRghtFwd, sRghtRev, prdStrt});
      else nPass++;
      nChecks++;
      if (sRghtDuty !== 11'd0 || rghtDuty !== 11'd0)
         $display("[TB] FAIL async_reset_duty: rght=%0d sat rght=%0d want 0", rghtDuty, sRghtDuty);
      else nPass++;
      @(negedge clk);
      rst = 1'b0;
      modelZero();
      firstPeriod = 1'b1;
      for (int p = 0; p < 2; p++) runPeriod(1'b0, -1, -1, 1'b1);
   endtask

   task automatic test_enable_drop();
      runPeriod(1'b0, 400, 1000, 1'b0);
      runPeriod(1'b0, -1, -1, 1'b1);
   endtask

   initial begin
      test_reset();
      test_ramp_up();
      test_reversal();
      test_sampling_window();
      test_random();
      test_saturation();
      test_reset_mid();
      test_enable_drop();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
